// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector with run control, saturating detection counter
// and a stop threshold. Match flag is Mealy (combinational on the final qualified bit).
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_cfg_overlap,
    input  logic [CNT_W-1:0]   i_cfg_threshold,
    output logic               o_cfg_err,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_x,
    input  logic               i_x_valid,
    output logic               o_seq_detected,
    output logic [CNT_W-1:0]   o_det_count,
    output logic               o_done,
    output logic               o_configured
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [MAX_LEN-1:0] pattern_q,    pattern_d;
    logic [LEN_W-1:0]   len_q,        len_d;
    logic               overlap_q,    overlap_d;
    logic [CNT_W-1:0]   thresh_q,     thresh_d;
    logic               configured_q, configured_d;
    logic               cfg_err_q,    cfg_err_d;
    logic [MAX_LEN-1:0] hist_q,       hist_d;
    logic [LEN_W-1:0]   fill_q,       fill_d;
    logic [CNT_W-1:0]   count_q,      count_d;

    logic [MAX_LEN-1:0] len_mask_s;
    logic [MAX_LEN-1:0] window_s;
    logic               fill_ok_s;
    logic               match_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               cfg_fire_s;
    logic               len_legal_s;

    // Mask selecting the low len bits of the pattern and history window.
    always_comb begin
        len_mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask_s[i] = (32'(i) < 32'(len_q));
        end
    end

    assign window_s    = {hist_q[MAX_LEN-2:0], i_x};
    assign fill_ok_s   = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
    assign match_s     = (state_q == ST_ARMED) && i_x_valid && !i_stop && fill_ok_s &&
                         ((window_s & len_mask_s) == (pattern_q & len_mask_s));
    assign fill_inc_s  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign count_inc_s = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
    assign cfg_fire_s  = i_cfg_valid && (state_q == ST_IDLE);
    assign len_legal_s = (i_cfg_len != LEN_W'(0)) && (i_cfg_len <= LEN_W'(MAX_LEN));

    // Next-state logic: configuration capture, run control and matching datapath.
    always_comb begin
        state_d      = state_q;
        pattern_d    = pattern_q;
        len_d        = len_q;
        overlap_d    = overlap_q;
        thresh_d     = thresh_q;
        configured_d = configured_q;
        cfg_err_d    = 1'b0;
        hist_d       = hist_q;
        fill_d       = fill_q;
        count_d      = count_q;

        if (cfg_fire_s && len_legal_s) begin
            pattern_d    = i_cfg_pattern;
            len_d        = i_cfg_len;
            overlap_d    = i_cfg_overlap;
            thresh_d     = i_cfg_threshold;
            configured_d = 1'b1;
        end else if (cfg_fire_s) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop && configured_q) begin
                    state_d = ST_ARMED;
                    count_d = {CNT_W{1'b0}};
                    fill_d  = {LEN_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (i_x_valid) begin
                    hist_d = window_s;
                    if (match_s) begin
                        count_d = count_inc_s;
                        // Non-overlap restarts collection so no bits are shared between matches.
                        fill_d  = overlap_q ? fill_inc_s : {LEN_W{1'b0}};
                        if ((thresh_q != {CNT_W{1'b0}}) && (count_inc_s == thresh_q)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        fill_d = fill_inc_s;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_DONE: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (i_start) begin
                    state_d = ST_ARMED;
                    count_d = {CNT_W{1'b0}};
                    fill_d  = {LEN_W{1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops the held configuration.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            pattern_q    <= {MAX_LEN{1'b0}};
            len_q        <= {LEN_W{1'b0}};
            overlap_q    <= 1'b0;
            thresh_q     <= {CNT_W{1'b0}};
            configured_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            hist_q       <= {MAX_LEN{1'b0}};
            fill_q       <= {LEN_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            overlap_q    <= overlap_d;
            thresh_q     <= thresh_d;
            configured_q <= configured_d;
            cfg_err_q    <= cfg_err_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            count_q      <= count_d;
        end
    end

    assign o_cfg_ready    = (state_q == ST_IDLE);
    assign o_done         = (state_q == ST_DONE);
    assign o_det_count    = count_q;
    assign o_cfg_err      = cfg_err_q;
    assign o_configured   = configured_q;
    assign o_seq_detected = match_s;

endmodule
